// File: rtl/mod_exp_seq.sv
// mod_exp_seq: res = a^e mod n through one shared Montgomery multiplier (req/ack), LSB-first square-and-multiply.
// Stalls on mm_ack indefinitely, ignores start while busy; define MOD_EXP_SEQ_PERF_EN to add perf_cycles/perf_ops counters.
module mod_exp_seq #(
    parameter int LEN = 256,
    parameter int EW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] a,
    input  logic [EW-1:0]  e,
    input  logic [LEN-1:0] r2_mod_n,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] res,
    output logic           mm_req,
    output logic [LEN-1:0] mm_a,
    output logic [LEN-1:0] mm_b,
    input  logic           mm_ack,
    input  logic [LEN-1:0] mm_res
`ifdef MOD_EXP_SEQ_PERF_EN
    ,
    output logic [31:0]    perf_cycles,
    output logic [15:0]    perf_ops
`endif
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [LEN-1:0] ONE = {{(LEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_TO_MONT, S_INIT, S_BIT, S_MUL, S_SQR, S_FROM_MONT, S_DONE
    } state_t;

    state_t         state, state_next;
    logic [LEN-1:0] base, acc;
    logic [EW-1:0]  ereg;
    logic [IW-1:0]  idx, top;
    logic           accept, op_state, op_done;
    logic [LEN-1:0] op_a, op_b;

    function automatic logic [IW-1:0] msb_index(input logic [EW-1:0] v);
        msb_index = '0;
        for (int k = 0; k < EW; k++)
            if (v[k]) msb_index = IW'(k);
    endfunction

    // An ack only counts while our own request is outstanding.
    assign op_done = mm_req && mm_ack;
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        op_state   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_TO_MONT;
                end
            end
            S_TO_MONT: begin
                op_state = 1'b1;
                op_a     = base;
                op_b     = r2_mod_n;
                if (op_done) state_next = S_INIT;
            end
            S_INIT: begin
                op_state = 1'b1;
                op_a     = r2_mod_n;
                op_b     = ONE;
                if (op_done) state_next = (ereg == '0) ? S_FROM_MONT : S_BIT;
            end
            S_BIT: begin
                state_next = ereg[idx] ? S_MUL : S_SQR;
            end
            S_MUL: begin
                op_state = 1'b1;
                op_a     = acc;
                op_b     = base;
                if (op_done) state_next = (idx == top) ? S_FROM_MONT : S_SQR;
            end
            S_SQR: begin
                op_state = 1'b1;
                op_a     = base;
                op_b     = base;
                if (op_done) state_next = S_BIT;
            end
            S_FROM_MONT: begin
                op_state = 1'b1;
                op_a     = acc;
                op_b     = ONE;
                if (op_done) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request goes up one cycle after entering an op state, so every op is preceded by an idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            acc    <= '0;
            ereg   <= '0;
            idx    <= '0;
            top    <= '0;
            res    <= '0;
            mm_req <= 1'b0;
            mm_a   <= '0;
            mm_b   <= '0;
        end else begin
            if (accept) begin
                base <= a;
                ereg <= e;
                top  <= msb_index(e);
                idx  <= '0;
            end
            if (op_state && !mm_req) begin
                mm_req <= 1'b1;
                mm_a   <= op_a;
                mm_b   <= op_b;
            end
            if (op_done) begin
                mm_req <= 1'b0;
                case (state)
                    S_TO_MONT, S_SQR: base <= mm_res;
                    S_INIT, S_MUL:    acc  <= mm_res;
                    S_FROM_MONT:      res  <= mm_res;
                    default:          ;
                endcase
                if (state == S_SQR)  idx <= idx + 1'b1;
                if (state == S_INIT) idx <= '0;
            end
        end
    end

`ifdef MOD_EXP_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_ops    <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
            perf_ops    <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
            if (op_done && (perf_ops != '1)) perf_ops    <= perf_ops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mod_exp_seq.sv
// Bench for mod_exp_seq at LEN=8, n=7 with a behavioural Montgomery multiplier and a result scoreboard.
module tb_mod_exp_seq;

    localparam int N_MOD = 7;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] e;
    logic [7:0] r2_mod_n;
    logic       busy;
    logic       done;
    logic [7:0] res;
    logic       mm_req;
    logic [7:0] mm_a;
    logic [7:0] mm_b;
    logic       mm_ack;
    logic [7:0] mm_res;
`ifdef MOD_EXP_SEQ_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_ops;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] op_log[$];
    int          lat_mode = 0;
    bit          spur_gap = 1'b0;
    int          spur_req_cnt = 0;
    int          spur_done_cnt = 0;

    mod_exp_seq #(.LEN(8), .EW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .e        (e),
        .r2_mod_n (r2_mod_n),
        .busy     (busy),
        .done     (done),
        .res      (res),
        .mm_req   (mm_req),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_ack   (mm_ack),
        .mm_res   (mm_res)
`ifdef MOD_EXP_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_ops    (perf_ops)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // A*B*R^-1 mod n, found by searching for x with x*R == A*B (mod n).
    function automatic logic [7:0] mont(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = (int'(x) * int'(y)) % N_MOD;
        mont = 8'h00;
        for (int c = N_MOD - 1; c >= 0; c--)
            if (((c * 256) % N_MOD) == p) mont = 8'(c);
    endfunction

    function automatic logic [7:0] ref_pow(input logic [7:0] b, input logic [7:0] x);
        int r;
        r = 1 % N_MOD;
        for (int i = 0; i < int'(x); i++) r = (r * int'(b)) % N_MOD;
        return 8'(r);
    endfunction

    function automatic int exp_ops(input logic [7:0] x);
        int c;
        int t;
        c = 3;
        t = 0;
        for (int i = 0; i < 8; i++)
            if (x[i]) begin
                c++;
                t = i;
            end
        return c + t;
    endfunction

    initial begin : mm_model
        int lat;
        logic [7:0] ha;
        logic [7:0] hb;
        bit aborted;
        mm_ack = 1'b0;
        mm_res = 8'h00;
        forever begin
            @(negedge clk);
            mm_ack = 1'b0;
            if (mm_req) begin
                ha = mm_a;
                hb = mm_b;
                op_log.push_back({ha, hb});
                lat = (lat_mode == 1) ? 1 : (lat_mode == 2) ? 10 : int'($urandom_range(1, 10));
                aborted = 1'b0;
                for (int k = 1; k < lat; k++) begin
                    @(negedge clk);
                    if (!mm_req) begin
                        aborted = 1'b1;
                        break;
                    end
                    check_eq("mm_a_hold", 32'(mm_a), 32'(ha));
                    check_eq("mm_b_hold", 32'(mm_b), 32'(hb));
                end
                if (!aborted) begin
                    mm_ack = 1'b1;
                    mm_res = mont(ha, hb);
                    @(negedge clk);
                    mm_ack = 1'b0;
                    check_eq("mm_req_drop", 32'(mm_req), 32'd0);
                    if (spur_gap) begin
                        mm_ack = 1'b1;
                        mm_res = 8'h33;
                    end
                end
            end else if (spur_req_cnt != spur_done_cnt) begin
                mm_ack = 1'b1;
                mm_res = 8'h55;
                spur_done_cnt++;
            end
        end
    end

    initial begin : monitor
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (done) begin
                check_eq("done_busy", 32'(busy), 32'd0);
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check_eq("res", 32'(res), 32'(want));
                end
                @(negedge clk);
                check_eq("done_pulse", 32'(done), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic run_exp(input logic [7:0] av, input logic [7:0] ev, input int inj_at, output int bcyc);
        int  ob;
        bit  seen;
        ob = op_log.size();
        @(negedge clk);
        a = av;
        e = ev;
        start = 1'b1;
        exp_q.push_back(ref_pow(av, ev));
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_set", 32'(busy), 32'd1);
        bcyc = 0;
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcyc++;
            start = (c == inj_at);
            if (c == inj_at) begin
                a = 8'd2;
                e = 8'd3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("op_count", 32'(op_log.size() - ob), 32'(exp_ops(ev)));
    endtask

    logic [15:0] exp_seq [7] = '{16'h0302, 16'h0201, 16'h0405, 16'h0505, 16'h0101, 16'h0502, 16'h0601};

    initial begin : main
        int  bc;
        int  ob;
        bit  seen;
        rst = 1'b1;
        start = 1'b0;
        a = 8'd0;
        e = 8'd0;
        r2_mod_n = 8'd2;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_req", 32'(mm_req), 32'd0);
        check_eq("rst_res", 32'(res), 32'd0);
        check_eq("rst_mm_a", 32'(mm_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reference vector with op-order check
        lat_mode = 1;
        ob = op_log.size();
        run_exp(8'd3, 8'd5, -1, bc);
        for (int i = 0; i < 7; i++)
            check_eq("op_order", 32'(op_log[ob + i]), 32'(exp_seq[i]));

        lat_mode = 0;
        run_exp(8'd3, 8'd0, -1, bc);
        run_exp(8'd0, 8'd4, -1, bc);
        run_exp(8'd6, 8'd255, -1, bc);
        run_exp(8'd5, 8'd128, -1, bc);

        spur_gap = 1'b1;
        run_exp(8'd3, 8'd5, -1, bc);
        spur_gap = 1'b0;

        // Second start and input changes while busy must be ignored
        run_exp(8'd3, 8'd5, 5, bc);
        run_exp(8'd2, 8'd3, -1, bc);

        // Abort in SQR with a request outstanding
        lat_mode = 2;
        ob = op_log.size();
        @(negedge clk);
        a = 8'd3;
        e = 8'd5;
        start = 1'b1;
        exp_q.push_back(8'd5);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if ((op_log.size() - ob >= 4) && mm_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("sqr_reached", 32'(seen), 32'd1);
        check_eq("sqr_mm_a", 32'(mm_a), 32'd5);
        check_eq("sqr_mm_b", 32'(mm_b), 32'd5);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_req", 32'(mm_req), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_res", 32'(res), 32'd0);
        check_eq("abort_mm_a", 32'(mm_a), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        spur_req_cnt++;
        repeat (4) @(negedge clk);
        check_eq("late_ack_req", 32'(mm_req), 32'd0);
        check_eq("late_ack_busy", 32'(busy), 32'd0);
        check_eq("late_ack_res", 32'(res), 32'd0);
        check_eq("late_ack_sent", 32'(spur_done_cnt), 32'(spur_req_cnt));

        lat_mode = 0;
        run_exp(8'd3, 8'd5, -1, bc);

`ifdef MOD_EXP_SEQ_PERF_EN
        lat_mode = 1;
        run_exp(8'd3, 8'd5, -1, bc);
        check_eq("perf_ops", 32'(perf_ops), 32'd7);
        check_eq("perf_cycles", perf_cycles, 32'(bc));
        repeat (5) @(negedge clk);
        check_eq("perf_cycles_hold", perf_cycles, 32'(bc));
`endif

        repeat (5) @(negedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
